// File: rtl/load_store_unit.sv
// Data-memory initiator for RV32I loads/stores. Sub-word stores are done as
// read-modify-write of the containing word because the memory only writes words.
module load_store_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_memrw,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_write,
  input  logic [31:0]       mem_data_read
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  state_e            state_q, state_d;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              accept;
  logic              legal;
  logic              misaligned;
  logic              req_err;
  logic [ADDR_W-1:0] word_addr;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [31:0]       load_val;
  logic [31:0]       merged;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

  // Request classification is done on the live inputs so the error path
  // can skip memory entirely.
  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    case (req_funct3)
      3'd0, 3'd1, 3'd2: legal = 1'b1;
      3'd4, 3'd5:       legal = !req_we;
      default:          legal = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    req_err = !legal || misaligned;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                               state_d = DONE;
          else if (req_we && req_funct3[1:0] == 2'd2) state_d = WR;
          else                                       state_d = RD;
        end
      end
      RD:      state_d = we_q ? WR : DONE;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= req_err;
      end
      if (state_q == RD) rdata_q <= mem_data_read;
    end
  end

  always_comb begin
    lane_byte = rdata_q[{addr_q[1:0], 3'b000} +: 8];
    lane_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (funct3_q)
      3'd0:    load_val = {{24{lane_byte[7]}}, lane_byte};
      3'd1:    load_val = {{16{lane_half[15]}}, lane_half};
      3'd4:    load_val = {24'd0, lane_byte};
      3'd5:    load_val = {16'd0, lane_half};
      default: load_val = rdata_q;
    endcase
  end

  always_comb begin
    merged = rdata_q;
    case (funct3_q[1:0])
      2'd0: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'd1: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  assign mem_memrw      = (state_q == WR);
  assign mem_address    = (state_q == RD || state_q == WR) ? word_addr : '0;
  assign mem_data_write = (state_q == WR) ? merged : '0;
  assign resp_valid     = (state_q == DONE);
  assign resp_err       = (state_q == DONE) && err_q;
  assign resp_rdata     = (state_q == DONE && !we_q && !err_q) ? load_val : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, multi-cycle corner
// sequences and random traffic against a byte-level reference memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_memrw;
  logic [31:0] mem_address;
  logic [31:0] mem_data_write;
  logic [31:0] mem_data_read;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_memrw      (mem_memrw),
    .mem_address    (mem_address),
    .mem_data_write (mem_data_write),
    .mem_data_read  (mem_data_read)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Environment memory (no reset) and the bench's own reference copy.
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  assign mem_data_read = mem[mem_address[9:2]];
  always @(posedge clk) if (mem_memrw === 1'b1) mem[mem_address[9:2]] <= mem_data_write;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          resp_cnt = 0;
  int          act_cnt  = 0;
  logic        prev_rw  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_memrw === 1'b1) begin
      wr_addr_q.push_back(mem_address);
      wr_data_q.push_back(mem_data_write);
      check("no_consecutive_writes", {31'd0, prev_rw}, 32'd0);
    end
    if (mem_memrw === 1'b1 || resp_valid === 1'b1)
      check("ready_low_when_busy", {31'd0, req_ready}, 32'd0);
    if (resp_valid === 1'b1) resp_cnt++;
    if (mem_memrw === 1'b1 || (mem_address !== 32'd0 && !$isunknown(mem_address))) act_cnt++;
    prev_rw = (mem_memrw === 1'b1);
  end

  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic err,
                                output logic [31:0] rdata, output int cyc,
                                output logic [31:0] neww);
    logic [31:0] word, v, mask;
    logic        legal;
    int          size, off;
    word  = ref_mem[addr[9:2]];
    off   = int'(addr[1:0]);
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    err   = !legal || ((off % size) != 0);
    rdata = 32'd0;
    neww  = word;
    cyc   = err ? 1 : 2;
    if (!err && !we) begin
      v = word >> (8 * off);
      if (size == 1) begin
        v = v & 32'hFF;
        if (!f3[2] && v >= 32'd128) v = v | 32'hFFFF_FF00;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (!f3[2] && v >= 32'd32768) v = v | 32'hFFFF_0000;
      end
      rdata = v;
    end else if (!err && we) begin
      if (size == 4) neww = wdata;
      else begin
        mask = ((32'd1 << (8 * size)) - 32'd1) << (8 * off);
        neww = (word & ~mask) | ((wdata << (8 * off)) & mask);
        cyc  = 3;
      end
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  {31'd0, req_ready},  32'd1);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata,          32'd0);
    check({tag, "_resp_err"},   {31'd0, resp_err},   32'd0);
    check({tag, "_mem_memrw"},  {31'd0, mem_memrw},  32'd0);
    check({tag, "_mem_addr"},   mem_address,         32'd0);
    check({tag, "_mem_wdata"},  mem_data_write,      32'd0);
  endtask

  // Issues one request from idle and checks response latency, data and writes.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input int exp_cyc, input logic [31:0] exp_wr);
    int wr0, act0, got, exp_nwr;
    check({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
    wr0  = wr_addr_q.size();
    act0 = act_cnt;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    got = 0;
    for (int c = 1; c <= 6 && got == 0; c++) begin
      if (resp_valid === 1'b1) begin
        got = c;
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
      end else begin
        @(posedge clk); #1;
      end
    end
    check({tag, "_latency"}, got, exp_cyc);
    @(posedge clk); #1;
    check({tag, "_single_pulse"}, {31'd0, resp_valid}, 32'd0);
    exp_nwr = (we && !exp_err) ? 1 : 0;
    check({tag, "_nwrites"}, wr_addr_q.size() - wr0, exp_nwr);
    if (exp_nwr == 1 && wr_addr_q.size() == wr0 + 1) begin
      check({tag, "_wr_addr"}, wr_addr_q[wr0], {addr[31:2], 2'b00});
      check({tag, "_wr_data"}, wr_data_q[wr0], exp_wr);
    end
    if (exp_err) check({tag, "_no_mem_activity"}, act_cnt - act0, 0);
    if (we && !exp_err) ref_mem[addr[9:2]] = exp_wr;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
    logic [31:0] wr;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic        e_err;
    logic [31:0] e_rd, e_new, a, d;
    int          e_cyc, wr0, r0;
    logic [31:0] bb_data[3];
    logic        we;
    logic [2:0]  f3;

    vecs[0]  = '{"sw_10",    1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        2, 32'hDEADBEEF};
    vecs[1]  = '{"lb_13",    1'b0, 3'd0, 32'h13, 32'h0,        1'b0, 32'hFFFFFFDE, 2, 32'h0};
    vecs[2]  = '{"lbu_13",   1'b0, 3'd4, 32'h13, 32'h0,        1'b0, 32'h000000DE, 2, 32'h0};
    vecs[3]  = '{"lh_12",    1'b0, 3'd1, 32'h12, 32'h0,        1'b0, 32'hFFFFDEAD, 2, 32'h0};
    vecs[4]  = '{"lhu_10",   1'b0, 3'd5, 32'h10, 32'h0,        1'b0, 32'h0000BEEF, 2, 32'h0};
    vecs[5]  = '{"lw_10",    1'b0, 3'd2, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 2, 32'h0};
    vecs[6]  = '{"sw_20",    1'b1, 3'd2, 32'h20, 32'h11223344, 1'b0, 32'h0,        2, 32'h11223344};
    vecs[7]  = '{"sb_21",    1'b1, 3'd0, 32'h21, 32'h000000AB, 1'b0, 32'h0,        3, 32'h1122AB44};
    vecs[8]  = '{"sh_22",    1'b1, 3'd1, 32'h22, 32'h00005566, 1'b0, 32'h0,        3, 32'h5566AB44};
    vecs[9]  = '{"lw_20",    1'b0, 3'd2, 32'h20, 32'h0,        1'b0, 32'h5566AB44, 2, 32'h0};
    vecs[10] = '{"lw_mis22", 1'b0, 3'd2, 32'h22, 32'h0,        1'b1, 32'h0,        1, 32'h0};
    vecs[11] = '{"sh_mis21", 1'b1, 3'd1, 32'h21, 32'h1234,     1'b1, 32'h0,        1, 32'h0};
    vecs[12] = '{"ld_f3_3",  1'b0, 3'd3, 32'h40, 32'h0,        1'b1, 32'h0,        1, 32'h0};

    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++)
      do_req(vecs[i].name, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
             vecs[i].err, vecs[i].rdata, vecs[i].cyc, vecs[i].wr);

    // Back-to-back stores with req_valid held high throughout.
    bb_data[0] = 32'hA0A0_0001; bb_data[1] = 32'hB1B1_0002; bb_data[2] = 32'hC2C2_0003;
    wr0 = wr_addr_q.size();
    r0  = resp_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
    for (int k = 0; k < 3; k++) begin
      req_addr  = 32'h40 + 32'(4 * k);
      req_wdata = bb_data[k];
      for (int t = 0; t < 8 && req_ready !== 1'b1; t++) begin
        @(posedge clk); #1;
      end
      check("b2b_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("b2b_nwrites", wr_addr_q.size() - wr0, 3);
    check("b2b_nresp", resp_cnt - r0, 3);
    for (int k = 0; k < 3; k++) begin
      if (wr_addr_q.size() >= wr0 + 3) begin
        check("b2b_wr_addr", wr_addr_q[wr0 + k], 32'h40 + 32'(4 * k));
        check("b2b_wr_data", wr_data_q[wr0 + k], bb_data[k]);
      end
      ref_mem[16 + k] = bb_data[k];
    end

    // Reset during the WR cycle of an SB: merged write still lands, no response.
    model(1'b1, 3'd0, 32'h31, 32'h77, e_err, e_rd, e_cyc, e_new);
    wr0 = wr_addr_q.size();
    r0  = resp_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h31; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rstwr_in_wr", {31'd0, mem_memrw}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("rstwr");
    @(posedge clk); #1;
    check("rstwr_no_resp", resp_cnt - r0, 0);
    check("rstwr_nwrites", wr_addr_q.size() - wr0, 1);
    if (wr_addr_q.size() == wr0 + 1) begin
      check("rstwr_wr_addr", wr_addr_q[wr0], 32'h30);
      check("rstwr_wr_data", wr_data_q[wr0], e_new);
    end
    ref_mem[12] = e_new;
    model(1'b0, 3'd2, 32'h30, 32'h0, e_err, e_rd, e_cyc, e_new);
    do_req("rstwr_lw", 1'b0, 3'd2, 32'h30, 32'h0, e_err, e_rd, e_cyc, e_new);

    // Random traffic against the reference model.
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      d  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        else if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
      end
      model(we, f3, a, d, e_err, e_rd, e_cyc, e_new);
      do_req("rand", we, f3, a, d, e_err, e_rd, e_cyc, e_new);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface. Sits between the MEM pipeline stage and the word-wide data memory.
- Accepts one load or store request at a time. Handles RV32I LB/LH/LW/LBU/LHU/SB/SH/SW.
- The memory supports word writes only, so byte and halfword stores become a read-modify-write of the containing word.
- Loads return the extracted byte or halfword, sign- or zero-extended. The pipeline stalls while req_ready is low.

Parameters:
- ADDR_W, 32, width of req_addr and mem_address.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (size and sign).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data (rs2); the relevant low bits are used.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal funct3; valid with resp_valid.
- mem_memrw  out  1  1 = write, 0 = read.
- mem_address  out  ADDR_W  word-aligned address to memory.
- mem_data_write  out  32  word to write.
- mem_data_read  in  32  combinational read data for mem_address.

Behaviour:
- Reset: synchronous. rst high at a clock edge puts state in IDLE and clears all capture registers.
  - Reset output values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_memrw=0, mem_address=0, mem_data_write=0.
- Handshake: accept when req_valid && req_ready at an edge. req_ready = (state==IDLE).
  - At accept, capture req_we, req_funct3, req_addr and req_wdata. The requester may change its inputs afterwards.
- States: IDLE, RD, WR, DONE.
- Legal encodings:
  - Loads: funct3 0 (LB), 1 (LH), 2 (LW), 4 (LBU), 5 (LHU).
  - Stores: funct3 0 (SB), 1 (SH), 2 (SW).
  - Anything else is illegal.
- Misaligned: halfword access with addr[0]=1; word access with addr[1:0]!=0.
- Transitions from IDLE on accept:
  - Illegal or misaligned -> DONE. No memory access; resp_err=1.
  - Load, SB or SH -> RD.
  - SW -> WR.
- Other transitions:
  - RD -> DONE for a load, or -> WR for SB/SH.
  - WR -> DONE.
  - DONE -> IDLE.
- RD state:
  - Drives mem_address = {addr[ADDR_W-1:2],2'b00} with mem_memrw=0.
  - Registers mem_data_read at the edge ending RD.
- Load extraction from the captured word, using addr[1:0]:
  - LB/LBU select byte lane addr[1:0] (lane 0 = bits 7:0).
  - LH/LHU select half addr[1] (bits 15:0 or 31:16).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- WR state: drives mem_memrw=1, the aligned address, and mem_data_write.
  - SW writes req_wdata.
  - SH replaces only the addressed half of the RD word with req_wdata[15:0].
  - SB replaces only the addressed byte with req_wdata[7:0].
- Outside RD/WR: mem_memrw=0, mem_address=0, mem_data_write=0.
- mem_memrw is decoded from state only; it is never asserted in two consecutive cycles.
- DONE state: resp_valid=1 for exactly one cycle. resp_rdata holds the load result, or 0 for a store or error. resp_err is set as classified.
  - resp_rdata and resp_err are valid only while resp_valid=1; otherwise 0.
- Latency from the accept edge (N = cycle after accept):
  - Error: resp_valid in N.
  - Load: resp_valid in N+1.
  - SW: resp_valid in N+1.
  - SB/SH: resp_valid in N+2.
  - The next accept is possible in the cycle after DONE.
- Reset mid-operation: rst high during a WR cycle does not block that cycle's memory write, because the memory has no reset and commits the write. No further access is issued.
  - No resp_valid is produced for the aborted request.
- req_valid while not ready is ignored and does not queue.
- Address wrap: upper address bits pass through unchanged. Address decoding and range are the memory's concern.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF -> one WR cycle: mem_memrw=1, mem_address 0x10, mem_data_write 0xDEADBEEF. Then resp_valid, resp_err=0, resp_rdata=0. Total 2 cycles after accept.
- After that SW, LB addr 0x13 -> resp_rdata 0xFFFFFFDE. LBU 0x13 -> 0x000000DE. LH 0x12 -> 0xFFFFDEAD. LHU 0x10 -> 0x0000BEEF. LW 0x10 -> 0xDEADBEEF.
- Word 0x20 = 0x11223344; SB addr 0x21, wdata 0xAB -> RD then WR with mem_data_write 0x1122AB44. SH addr 0x22, wdata 0x5566 -> 0x5566AB44. resp_valid 3 cycles after accept.
- LW addr 0x22, SH addr 0x21, and load funct3 3 -> resp_err=1, resp_valid in the cycle after accept, mem_memrw never asserted, mem_address stays 0.
- Back-to-back: req_valid held high for 3 SW requests -> req_ready low during WR/DONE, each accepted exactly once, three writes in order, no dropped or duplicated resp_valid.
- rst asserted during the WR cycle of an SB -> that merged write occurs, next cycle is IDLE with all outputs at reset values, no resp_valid. A subsequent LW returns the merged word.
